// File: rtl/rgb_gray_stream_pkg.sv
// rtl/rgb_gray_stream_pkg.sv - shared constants, state encoding and luma helper for rgb_gray_stream
package rgb_gray_stream_pkg;

   localparam int DEF_WIDTH  = 128;
   localparam int DEF_HEIGHT = 128;
   localparam int IMG_SIZE   = DEF_WIDTH * DEF_HEIGHT;

   localparam logic [7:0]  COEF_R     = 8'd77;
   localparam logic [7:0]  COEF_G     = 8'd150;
   localparam logic [7:0]  COEF_B     = 8'd29;
   localparam logic [15:0] LUMA_ROUND = 16'd128;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   // Worst case 255*(77+150+29)+128 = 65408, so 16 bits never overflow.
   function automatic logic [7:0] luma(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      logic [15:0] acc;
      acc = 16'(COEF_R) * 16'(r) + 16'(COEF_G) * 16'(g) + 16'(COEF_B) * 16'(b) + LUMA_ROUND;
      return acc[15:8];
   endfunction

endpackage

// File: rtl/rgb_gray_stream_if.sv
// rtl/rgb_gray_stream_if.sv - plane read port and luma output stream of rgb_gray_stream
interface rgb_gray_stream_if #(
   parameter int ADDR_W = 14
);
   logic [ADDR_W-1:0] addr;
   logic [7:0]        rdata_r;
   logic [7:0]        rdata_g;
   logic [7:0]        rdata_b;
   logic              out_valid;
   logic              out_ready;
   logic [7:0]        out_data;
   logic              out_last;

   modport master (
      output addr,
      input  rdata_r,
      input  rdata_g,
      input  rdata_b,
      output out_valid,
      input  out_ready,
      output out_data,
      output out_last
   );

   modport slave (
      input  addr,
      output rdata_r,
      output rdata_g,
      output rdata_b,
      input  out_valid,
      output out_ready,
      input  out_data,
      input  out_last
   );
endinterface

// File: rtl/rgb_gray_stream_sync_fifo.sv
// rtl/rgb_gray_stream_sync_fifo.sv - small synchronous FIFO with occupancy count and combinational head
module sync_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       pop_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_pop;

   assign empty  = (count == '0);
   assign full   = (count == (AW+1)'(DEPTH));
   assign do_pop = pop & ~empty;

   // An empty FIFO presents zeros so the stream outputs read 0 after reset.
   assign pop_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + AW'(1);
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         case ({push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/rgb_gray_stream.sv
// rtl/rgb_gray_stream.sv - raster-order RGB plane reader producing a backpressured 8-bit luma stream
module rgb_gray_stream
   import rgb_gray_stream_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int HEIGHT     = DEF_HEIGHT,
   parameter int ADDR_W     = $clog2(IMG_SIZE),
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   rgb_gray_stream_if.master bus,
   output logic              busy,
   output logic              done
);
   localparam int IMG = WIDTH * HEIGHT;
   localparam int CW  = $clog2(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IMG - 1);

   state_t            state;
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W-1:0] addr_q;
   logic              rd_pend;
   logic              rd_last;
   logic              y_valid;
   logic              y_last;
   logic [7:0]        y_data;
   logic [CW:0]       fifo_count;
   logic              fifo_full;
   logic              fifo_empty;
   logic [8:0]        head;
   logic [CW+1:0]     occupancy;
   logic              issue;
   logic              pop;

   // Every read in flight has a FIFO slot reserved, so stalls never drop a pixel.
   assign occupancy = {1'b0, fifo_count} + (CW+2)'(rd_pend) + (CW+2)'(y_valid);
   assign issue     = (state == S_RUN) && (occupancy < (CW+2)'(FIFO_DEPTH));
   assign pop       = ~fifo_empty & bus.out_ready;

   assign bus.addr      = addr_q;
   assign bus.out_valid = ~fifo_empty;
   assign bus.out_data  = head[7:0];
   assign bus.out_last  = head[8];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         idx     <= '0;
         addr_q  <= '0;
         rd_pend <= 1'b0;
         rd_last <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         rd_pend <= issue;
         rd_last <= issue && (idx == LAST_IDX);
         done    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_RUN;
                  idx   <= '0;
                  busy  <= 1'b1;
               end
            end
            S_RUN: begin
               if (issue) begin
                  addr_q <= idx;
                  if (idx == LAST_IDX) state <= S_DRAIN;
                  else                 idx   <= idx + ADDR_W'(1);
               end
            end
            S_DRAIN: begin
               if (!rd_pend && !y_valid && fifo_empty) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         y_valid <= 1'b0;
         y_last  <= 1'b0;
         y_data  <= '0;
      end else begin
         y_valid <= rd_pend;
         if (rd_pend) begin
            y_data <= luma(bus.rdata_r, bus.rdata_g, bus.rdata_b);
            y_last <= rd_last;
         end
      end
   end

   sync_fifo #(
      .WIDTH (9),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (reset),
      .push      (y_valid & ~fifo_full),
      .push_data ({y_last, y_data}),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_rgb_gray_stream.sv
// tb/tb_rgb_gray_stream.sv - randomized self-checking bench for rgb_gray_stream against a luma reference model
module tb_rgb_gray_stream;
   localparam int W     = 128;
   localparam int H     = 128;
   localparam int IMG   = W * H;
   localparam int DEPTH = 4;
   localparam int AW    = 14;

   logic clk = 1'b0;
   logic reset;
   logic start;
   logic busy;
   logic done;

   rgb_gray_stream_if #(.ADDR_W(AW)) bus ();

   rgb_gray_stream #(
      .WIDTH      (W),
      .HEIGHT     (H),
      .ADDR_W     (AW),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .bus   (bus),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   logic [7:0] mem_r [IMG];
   logic [7:0] mem_g [IMG];
   logic [7:0] mem_b [IMG];

   // Registered address plus asynchronous array read gives the one-cycle read latency.
   assign bus.rdata_r = mem_r[bus.addr];
   assign bus.rdata_g = mem_g[bus.addr];
   assign bus.rdata_b = mem_b[bus.addr];

   int pass_cnt = 0;
   int total_cnt = 0;
   int edge_n = 0;
   int start_edge = 1 << 30;
   int first_valid_edge;
   int last_accept_edge;
   int max_occ;
   int push_full;
   int busy_bad;
   int stall_bad;
   bit finished;
   logic [8:0] got_q [$];
   int done_edges [$];

   function automatic logic [7:0] ref_luma(input int r, input int g, input int b);
      int y;
      y = (77 * r + 150 * g + 29 * b + 128) / 256;
      return y[7:0];
   endfunction

   function automatic int first_diff();
      for (int i = 0; i < got_q.size() && i < IMG; i++) begin
         if (got_q[i] !== {(i == IMG - 1), ref_luma(int'(mem_r[i]), int'(mem_g[i]), int'(mem_b[i]))})
            return i;
      end
      return -1;
   endfunction

   task automatic cycle(input logic rdy, input logic st);
      int occ;
      @(posedge clk);
      #1;
      edge_n++;
      if (bus.out_valid && first_valid_edge < 0) first_valid_edge = edge_n;
      if (done) done_edges.push_back(edge_n);
      if (!reset && !done && !busy && edge_n >= start_edge && done_edges.size() == 0) busy_bad++;
      occ = int'(dut.fifo_count) + int'(dut.rd_pend) + int'(dut.y_valid);
      if (occ > max_occ) max_occ = occ;
      if (dut.y_valid && dut.fifo_full) push_full++;
      start = st;
      bus.out_ready = rdy;
      if (bus.out_valid && rdy) begin
         got_q.push_back({bus.out_last, bus.out_data});
         last_accept_edge = edge_n + 1;
      end
   endtask

   task automatic run_frame(input bit rand_ready, input int stall_at, input int abort_at, input bit poke);
      logic rdy;
      logic st;
      int stall_left;
      bit stalled;
      bit poked_run;
      bit poked_drain;
      logic [7:0] stall_data;
      got_q.delete();
      done_edges.delete();
      first_valid_edge = -1;
      last_accept_edge = -1;
      max_occ = 0;
      push_full = 0;
      busy_bad = 0;
      stall_bad = 0;
      finished = 1'b0;
      stall_left = 0;
      stalled = 1'b0;
      poked_run = 1'b0;
      poked_drain = 1'b0;
      stall_data = '0;
      start_edge = edge_n + 2;
      cycle(1'b1, 1'b1);
      for (int n = 0; n < 40000; n++) begin
         rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         st = 1'b0;
         if (stall_at >= 0 && !stalled && int'(got_q.size()) == stall_at) begin
            stalled = 1'b1;
            stall_left = 100;
         end
         if (stall_left > 0) rdy = 1'b0;
         if (poke && !poked_run && got_q.size() == 100) begin
            poked_run = 1'b1;
            st = 1'b1;
         end
         if (poke && !poked_drain && got_q.size() == IMG - 2) begin
            poked_drain = 1'b1;
            st = 1'b1;
         end
         cycle(rdy, st);
         if (stall_left > 0) begin
            if (!bus.out_valid) stall_bad++;
            if (stall_left == 100) stall_data = bus.out_data;
            else if (bus.out_data !== stall_data) stall_bad++;
            stall_left--;
         end
         if (abort_at >= 0 && int'(got_q.size()) >= abort_at) begin
            finished = 1'b1;
            break;
         end
         if (done_edges.size() > 0 && edge_n >= done_edges[0] + 4) begin
            finished = 1'b1;
            break;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      total_cnt++; if (bus.addr !== '0) $display("FAIL reset_addr: got %0d want 0", bus.addr); else pass_cnt++;
      total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else pass_cnt++;
      total_cnt++; if (bus.out_data !== 8'd0) $display("FAIL reset_out_data: got %0d want 0", bus.out_data); else pass_cnt++;
      total_cnt++; if (bus.out_last !== 1'b0) $display("FAIL reset_out_last: got %b want 0", bus.out_last); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
      reset = 1'b0;
      repeat (3) cycle(1'b1, 1'b0);
      total_cnt++; if (busy !== 1'b0 || bus.out_valid !== 1'b0) $display("FAIL idle_without_start: busy %b out_valid %b want 0 0", busy, bus.out_valid); else pass_cnt++;
   endtask

   task automatic test_constant_frame();
      int bad;
      int lasts;
      int de;
      for (int i = 0; i < IMG; i++) begin
         mem_r[i] = 8'd100;
         mem_g[i] = 8'd50;
         mem_b[i] = 8'd200;
      end
      run_frame(1'b0, -1, -1, 1'b1);
      bad = 0;
      lasts = 0;
      foreach (got_q[i]) begin
         if (got_q[i][7:0] !== 8'd82) bad++;
         if (got_q[i][8] !== 1'b0) lasts++;
      end
      de = (done_edges.size() > 0) ? done_edges[0] : -1;
      total_cnt++; if (!finished) $display("FAIL const_timeout: frame did not complete within budget"); else pass_cnt++;
      total_cnt++; if (got_q.size() != IMG) $display("FAIL const_count: got %0d samples want %0d", got_q.size(), IMG); else pass_cnt++;
      total_cnt++; if (bad != 0) $display("FAIL const_value: %0d samples differ from 82", bad); else pass_cnt++;
      total_cnt++; if (lasts != 1 || got_q.size() != IMG || got_q[IMG-1][8] !== 1'b1) $display("FAIL const_last: %0d last flags, want exactly one on final sample", lasts); else pass_cnt++;
      total_cnt++; if (first_valid_edge - start_edge != 3) $display("FAIL const_latency: got %0d cycles want 3", first_valid_edge - start_edge); else pass_cnt++;
      total_cnt++; if (done_edges.size() != 1) $display("FAIL const_done_count: got %0d pulses want 1", done_edges.size()); else pass_cnt++;
      total_cnt++; if (de - last_accept_edge != 1) $display("FAIL const_done_timing: got %0d cycles after last accept want 1", de - last_accept_edge); else pass_cnt++;
      total_cnt++; if (de < 0 || de - start_edge > IMG + 5) $display("FAIL const_total_cycles: got %0d want <= %0d", de - start_edge, IMG + 5); else pass_cnt++;
      total_cnt++; if (busy_bad != 0) $display("FAIL const_busy: busy low in %0d cycles of the frame, want 0", busy_bad); else pass_cnt++;
   endtask

   task automatic test_random_backpressure();
      logic [7:0] exp4 [4];
      int fd;
      exp4[0] = 8'd77;
      exp4[1] = 8'd149;
      exp4[2] = 8'd29;
      exp4[3] = 8'd255;
      for (int i = 0; i < IMG; i++) begin
         mem_r[i] = 8'($urandom);
         mem_g[i] = 8'($urandom);
         mem_b[i] = 8'($urandom);
      end
      mem_r[0] = 8'd255; mem_g[0] = 8'd0;   mem_b[0] = 8'd0;
      mem_r[1] = 8'd0;   mem_g[1] = 8'd255; mem_b[1] = 8'd0;
      mem_r[2] = 8'd0;   mem_g[2] = 8'd0;   mem_b[2] = 8'd255;
      mem_r[3] = 8'd255; mem_g[3] = 8'd255; mem_b[3] = 8'd255;
      run_frame(1'b1, -1, -1, 1'b0);
      fd = first_diff();
      total_cnt++; if (!finished) $display("FAIL rand_timeout: frame did not complete within budget"); else pass_cnt++;
      total_cnt++; if (got_q.size() != IMG) $display("FAIL rand_count: got %0d samples want %0d", got_q.size(), IMG); else pass_cnt++;
      total_cnt++; if (fd != -1) $display("FAIL rand_sequence: first mismatch at sample %0d", fd); else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         total_cnt++;
         if (got_q.size() <= i || got_q[i][7:0] !== exp4[i]) $display("FAIL rand_pixel%0d: got %0d want %0d", i, (got_q.size() > i) ? got_q[i][7:0] : 8'd0, exp4[i]);
         else pass_cnt++;
      end
      total_cnt++; if (max_occ > DEPTH) $display("FAIL rand_outstanding: got %0d want <= %0d", max_occ, DEPTH); else pass_cnt++;
      total_cnt++; if (push_full != 0) $display("FAIL rand_push_full: got %0d pushes into full FIFO want 0", push_full); else pass_cnt++;
      total_cnt++; if (done_edges.size() != 1) $display("FAIL rand_done_count: got %0d pulses want 1", done_edges.size()); else pass_cnt++;
   endtask

   task automatic test_reset_midframe();
      int fd;
      for (int i = 0; i < IMG; i++) begin
         mem_r[i] = 8'($urandom);
         mem_g[i] = 8'($urandom);
         mem_b[i] = 8'($urandom);
      end
      run_frame(1'b0, -1, 5000, 1'b0);
      total_cnt++; if (!finished) $display("FAIL abort_reach: only %0d samples before reset want 5000", got_q.size()); else pass_cnt++;
      reset = 1'b1;
      #2;
      total_cnt++; if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.addr !== '0) $display("FAIL abort_async_reset: out_valid %b busy %b addr %0d want 0 0 0", bus.out_valid, busy, bus.addr); else pass_cnt++;
      repeat (2) cycle(1'b1, 1'b0);
      reset = 1'b0;
      repeat (10) cycle(1'b1, 1'b0);
      total_cnt++; if (done_edges.size() != 0 || busy !== 1'b0) $display("FAIL abort_no_done: got %0d done pulses busy %b want 0 0", done_edges.size(), busy); else pass_cnt++;
      run_frame(1'b0, 2000, -1, 1'b0);
      fd = first_diff();
      total_cnt++; if (!finished) $display("FAIL restart_timeout: frame did not complete within budget"); else pass_cnt++;
      total_cnt++; if (got_q.size() != IMG) $display("FAIL restart_count: got %0d samples want %0d", got_q.size(), IMG); else pass_cnt++;
      total_cnt++; if (fd != -1) $display("FAIL restart_sequence: first mismatch at sample %0d", fd); else pass_cnt++;
      total_cnt++; if (stall_bad != 0) $display("FAIL stall_hold: %0d stall cycles lost valid or changed data want 0", stall_bad); else pass_cnt++;
      total_cnt++; if (max_occ > DEPTH) $display("FAIL stall_outstanding: got %0d want <= %0d", max_occ, DEPTH); else pass_cnt++;
      total_cnt++; if (done_edges.size() != 1) $display("FAIL restart_done_count: got %0d pulses want 1", done_edges.size()); else pass_cnt++;
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      bus.out_ready = 1'b0;
      test_reset();
      test_constant_frame();
      test_random_backpressure();
      test_reset_midframe();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
